// File: rtl/exmem_skid_reg.sv
// rtl/exmem_skid_reg.sv - elastic EX/MEM pipeline register with two-entry skid buffer and per-thread flush
// Optional stall counter output enabled by EXMEM_STALL_CNT_EN.
module exmem_skid_reg #(
    parameter int  PROC_DATA_WIDTH        = 16,
    parameter int  PROC_REGFILE_LOG2_DEEP = 5,
    parameter int  NUM_THREADS            = 4,
    localparam int THREAD_ID_W            = $clog2(NUM_THREADS)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic                              reg_write_en_i,
    input  logic                              mem_write_en_i,
    input  logic                              mem_read_en_i,
    input  logic                              mem_to_reg_i,
    input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
    input  logic [PROC_DATA_WIDTH-1:0]        reg_data2_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
    input  logic [THREAD_ID_W-1:0]            thread_id_i,
    input  logic [NUM_THREADS-1:0]            flush_mask_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              reg_write_en_o,
    output logic                              mem_write_en_o,
    output logic                              mem_read_en_o,
    output logic                              mem_to_reg_o,
    output logic [PROC_DATA_WIDTH-1:0]        alu_o,
    output logic [PROC_DATA_WIDTH-1:0]        reg_data2_o,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
    output logic [THREAD_ID_W-1:0]            thread_id_o
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [15:0]                       stall_cnt_o
`endif
);

    typedef struct packed {
        logic                              reg_write_en;
        logic                              mem_write_en;
        logic                              mem_read_en;
        logic                              mem_to_reg;
        logic [PROC_DATA_WIDTH-1:0]        alu;
        logic [PROC_DATA_WIDTH-1:0]        reg_data2;
        logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr;
        logic [THREAD_ID_W-1:0]            thread_id;
    } beat_t;

    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    beat_t in_beat;

    logic  accept, drain;
    logic  main_rem, skid_live, in_live;

    assign in_beat = '{reg_write_en:   reg_write_en_i,
                       mem_write_en:   mem_write_en_i,
                       mem_read_en:    mem_read_en_i,
                       mem_to_reg:     mem_to_reg_i,
                       alu:            alu_i,
                       reg_data2:      reg_data2_i,
                       reg_write_addr: reg_write_addr_i,
                       thread_id:      thread_id_i};

    assign ready_o = ~skid_valid_q;
    assign valid_o = main_valid_q;
    assign accept  = valid_i & ready_o;
    assign drain   = valid_o & ready_i;

    // Kill first, then retire MAIN on drain; whatever survives is compacted oldest-first.
    assign main_rem  = main_valid_q & ~flush_mask_i[main_q.thread_id] & ~drain;
    assign skid_live = skid_valid_q & ~flush_mask_i[skid_q.thread_id];
    assign in_live   = accept & ~flush_mask_i[thread_id_i];

    always_comb begin
        main_valid_d = 1'b0;
        main_d       = main_q;
        skid_valid_d = 1'b0;
        skid_d       = skid_q;
        if (main_rem) begin
            main_valid_d = 1'b1;
            if (skid_live) begin
                skid_valid_d = 1'b1;
            end else if (in_live) begin
                skid_valid_d = 1'b1;
                skid_d       = in_beat;
            end
        end else if (skid_live) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            if (in_live) begin
                skid_valid_d = 1'b1;
                skid_d       = in_beat;
            end
        end else if (in_live) begin
            main_valid_d = 1'b1;
            main_d       = in_beat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    // Control bits are gated so a bubble can never write the register file or memory.
    assign reg_write_en_o   = main_q.reg_write_en & main_valid_q;
    assign mem_write_en_o   = main_q.mem_write_en & main_valid_q;
    assign mem_read_en_o    = main_q.mem_read_en  & main_valid_q;
    assign mem_to_reg_o     = main_q.mem_to_reg   & main_valid_q;
    assign alu_o            = main_q.alu;
    assign reg_data2_o      = main_q.reg_data2;
    assign reg_write_addr_o = main_q.reg_write_addr;
    assign thread_id_o      = main_q.thread_id;

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_o && !ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exmem_skid_reg.sv
// tb/tb_exmem_skid_reg.sv - directed self-checking bench for exmem_skid_reg
module tb_exmem_skid_reg;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic        reg_write_en_i, mem_write_en_i, mem_read_en_i, mem_to_reg_i;
    logic [15:0] alu_i, reg_data2_i;
    logic [4:0]  reg_write_addr_i;
    logic [1:0]  thread_id_i;
    logic [3:0]  flush_mask_i;
    logic        valid_o;
    logic        ready_i;
    logic        reg_write_en_o, mem_write_en_o, mem_read_en_o, mem_to_reg_o;
    logic [15:0] alu_o, reg_data2_o;
    logic [4:0]  reg_write_addr_o;
    logic [1:0]  thread_id_o;
`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    exmem_skid_reg dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .reg_write_en_i   (reg_write_en_i),
        .mem_write_en_i   (mem_write_en_i),
        .mem_read_en_i    (mem_read_en_i),
        .mem_to_reg_i     (mem_to_reg_i),
        .alu_i            (alu_i),
        .reg_data2_i      (reg_data2_i),
        .reg_write_addr_i (reg_write_addr_i),
        .thread_id_i      (thread_id_i),
        .flush_mask_i     (flush_mask_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .reg_write_en_o   (reg_write_en_o),
        .mem_write_en_o   (mem_write_en_o),
        .mem_read_en_o    (mem_read_en_o),
        .mem_to_reg_o     (mem_to_reg_o),
        .alu_o            (alu_o),
        .reg_data2_o      (reg_data2_o),
        .reg_write_addr_o (reg_write_addr_o),
        .thread_id_o      (thread_id_o)
`ifdef EXMEM_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_beat(input logic [1:0] tid, input logic [15:0] alu, input logic mw);
        valid_i          = 1'b1;
        thread_id_i      = tid;
        alu_i            = alu;
        reg_data2_i      = ~alu;
        reg_write_addr_i = alu[4:0];
        mem_write_en_i   = mw;
        reg_write_en_i   = ~mw;
    endtask

    task automatic idle_inputs();
        valid_i        = 1'b0;
        reg_write_en_i = 1'b0;
        mem_write_en_i = 1'b0;
        mem_read_en_i  = 1'b0;
        mem_to_reg_i   = 1'b0;
        flush_mask_i   = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        alu_i = 16'h0; reg_data2_i = 16'h0; reg_write_addr_i = 5'd0; thread_id_i = 2'd0;
        ready_i = 1'b0;
        tick(); tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_o); else n_pass++;
        n_total++; if (alu_o !== 16'h0) $display("FAIL reset_alu got=%h exp=0000", alu_o); else n_pass++;
        n_total++; if (reg_data2_o !== 16'h0) $display("FAIL reset_data2 got=%h exp=0000", reg_data2_o); else n_pass++;
        n_total++; if ({reg_write_en_o, mem_write_en_o, mem_read_en_o, mem_to_reg_o} !== 4'b0)
            $display("FAIL reset_ctrl got=%b exp=0000", {reg_write_en_o, mem_write_en_o, mem_read_en_o, mem_to_reg_o});
        else n_pass++;
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive_beat(2'(i % 4), 16'(i), 1'b1);
            tick();
            n_total++; if (valid_o !== 1'b1) $display("FAIL stream_valid_%0d got=%b exp=1", i, valid_o); else n_pass++;
            n_total++; if (alu_o !== 16'(i)) $display("FAIL stream_alu_%0d got=%h exp=%h", i, alu_o, 16'(i)); else n_pass++;
            n_total++; if (ready_o !== 1'b1) $display("FAIL stream_ready_%0d got=%b exp=1", i, ready_o); else n_pass++;
        end
        n_total++; if (mem_write_en_o !== 1'b1) $display("FAIL stream_mw got=%b exp=1", mem_write_en_o); else n_pass++;
        idle_inputs();
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL stream_bubble_valid got=%b exp=0", valid_o); else n_pass++;
        n_total++; if (mem_write_en_o !== 1'b0) $display("FAIL stream_bubble_mw got=%b exp=0", mem_write_en_o); else n_pass++;
        n_total++; if (alu_o !== 16'h0008) $display("FAIL stream_hold_alu got=%h exp=0008", alu_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        drive_beat(2'd0, 16'h000A, 1'b0);
        tick();
        n_total++; if (alu_o !== 16'h000A || valid_o !== 1'b1) $display("FAIL bp_a_in got=%h/%b exp=000a/1", alu_o, valid_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL bp_ready_one got=%b exp=1", ready_o); else n_pass++;
        drive_beat(2'd1, 16'h000B, 1'b0);
        tick();
        n_total++; if (ready_o !== 1'b0) $display("FAIL bp_ready_full got=%b exp=0", ready_o); else n_pass++;
        n_total++; if (alu_o !== 16'h000A) $display("FAIL bp_hold_a got=%h exp=000a", alu_o); else n_pass++;
        drive_beat(2'd2, 16'h000C, 1'b0);
        tick();
        n_total++; if (alu_o !== 16'h000A || ready_o !== 1'b0) $display("FAIL bp_stall got=%h/%b exp=000a/0", alu_o, ready_o); else n_pass++;
        ready_i = 1'b1;
        tick();
        n_total++; if (alu_o !== 16'h000B || thread_id_o !== 2'd1) $display("FAIL bp_b_out got=%h/%0d exp=000b/1", alu_o, thread_id_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", ready_o); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (alu_o !== 16'h000C || valid_o !== 1'b1) $display("FAIL bp_c_out got=%h/%b exp=000c/1", alu_o, valid_o); else n_pass++;
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL bp_drained got=%b exp=0", valid_o); else n_pass++;
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive_beat(2'd1, 16'h0011, 1'b1);
        tick();
        drive_beat(2'd2, 16'h0022, 1'b0);
        tick();
        idle_inputs();
        n_total++; if (ready_o !== 1'b0 || thread_id_o !== 2'd1) $display("FAIL flush_setup got=%b/%0d exp=0/1", ready_o, thread_id_o); else n_pass++;
        flush_mask_i = 4'b0010;
        tick();
        flush_mask_i = 4'b0000;
        n_total++; if (valid_o !== 1'b1) $display("FAIL flush_valid got=%b exp=1", valid_o); else n_pass++;
        n_total++; if (thread_id_o !== 2'd2 || alu_o !== 16'h0022) $display("FAIL flush_compact got=%0d/%h exp=2/0022", thread_id_o, alu_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL flush_ready got=%b exp=1", ready_o); else n_pass++;
        n_total++; if (mem_write_en_o !== 1'b0) $display("FAIL flush_mw got=%b exp=0", mem_write_en_o); else n_pass++;
        ready_i = 1'b1;
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL flush_drain got=%b exp=0", valid_o); else n_pass++;
    endtask

    task automatic test_flush_incoming();
        ready_i = 1'b1;
        drive_beat(2'd3, 16'h0033, 1'b1);
        flush_mask_i = 4'b1000;
        n_total++; if (ready_o !== 1'b1) $display("FAIL flin_ready got=%b exp=1", ready_o); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (valid_o !== 1'b0) $display("FAIL flin_valid got=%b exp=0", valid_o); else n_pass++;
        n_total++; if (mem_write_en_o !== 1'b0) $display("FAIL flin_mw got=%b exp=0", mem_write_en_o); else n_pass++;
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL flin_stay got=%b exp=0", valid_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        drive_beat(2'd3, 16'h0055, 1'b1);
        tick();
        drive_beat(2'd2, 16'h0066, 1'b1);
        tick();
        idle_inputs();
        n_total++; if (ready_o !== 1'b0 || mem_write_en_o !== 1'b1) $display("FAIL ar_full got=%b/%b exp=0/1", ready_o, mem_write_en_o); else n_pass++;
        #2;
        rst_n_i = 1'b0;
        #1;
        n_total++; if (valid_o !== 1'b0) $display("FAIL ar_valid got=%b exp=0", valid_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL ar_ready got=%b exp=1", ready_o); else n_pass++;
        n_total++; if (alu_o !== 16'h0 || thread_id_o !== 2'd0 || reg_write_addr_o !== 5'd0)
            $display("FAIL ar_payload got=%h/%0d/%0d exp=0000/0/0", alu_o, thread_id_o, reg_write_addr_o);
        else n_pass++;
        n_total++; if (mem_write_en_o !== 1'b0) $display("FAIL ar_mw got=%b exp=0", mem_write_en_o); else n_pass++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        n_total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL ar_after got=%b/%b exp=0/1", valid_o, ready_o); else n_pass++;
    endtask

`ifdef EXMEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        ready_i = 1'b0;
        drive_beat(2'd0, 16'h0077, 1'b0);
        tick();
        idle_inputs();
        tick();
        n_total++; if (stall_cnt_o !== 16'd1) $display("FAIL stall_first got=%0d exp=1", stall_cnt_o); else n_pass++;
        repeat (70000) tick();
        n_total++; if (stall_cnt_o !== 16'hFFFF) $display("FAIL stall_sat got=%h exp=ffff", stall_cnt_o); else n_pass++;
        tick();
        n_total++; if (stall_cnt_o !== 16'hFFFF) $display("FAIL stall_hold got=%h exp=ffff", stall_cnt_o); else n_pass++;
        ready_i = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush();
        test_flush_incoming();
        test_async_reset();
`ifdef EXMEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
